// File: rtl/float_acc_to_log_encoder_pkg.sv
// float_log_pkg: shared types, bias helpers and the LUT generator function
// for the float-accumulator to log-number encoder.
//   exp_bias()       - IEEE-style bias 2^(w-1)-1 for a w-bit exponent
//   float_dec_t      - stage-1 decode record {sign, is_zero, is_inf, exp, frac}
//   range_t          - rebias outcome (in range / overflow / underflow)
//   log2_lut_entry() - round-nearest(2^frac * log2(1 + idx/2^k))
package float_log_pkg;

    // Decode record fields are sized for exponents/fractions up to 16 bits.
    localparam int DEC_EXP_W  = 20;
    localparam int DEC_FRAC_W = 17;

    // Fixed-point precision and guard bits used by the LUT generator.
    localparam int LUT_PREC  = 30;
    localparam int LUT_GUARD = 8;

    typedef struct packed {
        logic                        sign;
        logic                        is_zero;
        logic                        is_inf;
        logic signed [DEC_EXP_W-1:0] exp;   // unbiased input exponent
        logic [DEC_FRAC_W-1:0]       frac;  // LUT output, FRAC+1 bits used
    } float_dec_t;

    typedef enum logic [1:0] {
        RANGE_OK  = 2'd0,
        RANGE_OVF = 2'd1,
        RANGE_UNF = 2'd2
    } range_t;

    function automatic int exp_bias(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // log2 of 1.idx by repeated squaring: each squaring doubles the log, and
    // a result >= 2 yields the next fraction bit. Extra guard bits are
    // generated and then rounded away.
    function automatic int unsigned log2_lut_entry(input int unsigned idx,
                                                   input int k,
                                                   input int frac);
        logic [63:0] y;
        logic [63:0] two;
        int unsigned r;
        y   = 64'(idx) + (64'd1 << k);
        y   = (y << LUT_PREC) >> k;
        two = 64'd1 << (LUT_PREC + 1);
        r   = 0;
        for (int b = 0; b < frac + LUT_GUARD; b++) begin
            y = (y * y) >> LUT_PREC;
            r = r << 1;
            if (y >= two) begin
                r = r | 32'd1;
                y = y >> 1;
            end
        end
        return (r + (32'd1 << (LUT_GUARD - 1))) >> LUT_GUARD;
    endfunction

endpackage

// File: rtl/float_acc_to_log_encoder_if.sv
// Handshake/data bundle for float_acc_to_log_encoder.
//   inValid/inReady/inFloat    - accumulator word input
//   outValid/outReady/outLog   - packed log-number output
//   ovfCount/unfCount          - overflow/underflow event counters
// master: producer/consumer side (PE array read-out + activation buffer)
// slave : the encoder
interface float_acc_to_log_encoder_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 16
);
    logic             inValid;
    logic             inReady;
    logic [IN_W-1:0]  inFloat;
    logic             outValid;
    logic             outReady;
    logic [OUT_W-1:0] outLog;
    logic [15:0]      ovfCount;
    logic [15:0]      unfCount;

    modport master (
        output inValid, inFloat, outReady,
        input  inReady, outValid, outLog, ovfCount, unfCount
    );

    modport slave (
        input  inValid, inFloat, outReady,
        output inReady, outValid, outLog, ovfCount, unfCount
    );
endinterface

// File: rtl/float_acc_to_log_encoder_lut.sv
// float_to_log_lut: combinational log2(1.f) fraction table.
//   idx   [K-1:0]  - top K fraction bits of the input mantissa
//   entry [FRAC:0] - round-nearest(2^FRAC * log2(1 + idx/2^K)), 0..2^FRAC
// Table contents are generated at elaboration from log2_lut_entry().
module float_to_log_lut
    import float_log_pkg::*;
#(
    parameter int K    = 7,
    parameter int FRAC = 7
) (
    input  logic [K-1:0]  idx,
    output logic [FRAC:0] entry
);

    logic [FRAC:0] lut_rom [2**K];

    for (genvar i = 0; i < 2**K; i++) begin : g_rom
        localparam int unsigned VAL = log2_lut_entry(i, K, FRAC);
        assign lut_rom[i] = (FRAC + 1)'(VAL);
    end

    assign entry = lut_rom[idx];

endmodule

// File: rtl/float_acc_to_log_encoder.sv
// float_acc_to_log_encoder: converts linear float accumulator words into
// packed log numbers {sign, biased log exp, log frac} through a 2-stage
// valid/ready pipeline (full throughput, backpressure, depth 2).
//   clock  - sole clock
//   resetN - asynchronous active-low reset; drops in-flight words
//   bus    - float_acc_to_log_encoder_if.slave (handshakes, data, counters)
// Optional feature: define FLOAT_TO_LOG_STATS_EN to build the saturating
// overflow/underflow counters; otherwise ovfCount/unfCount are tied to 0.
module float_acc_to_log_encoder
    import float_log_pkg::*;
#(
    parameter int ACC_EXP            = 8,
    parameter int ACC_FRAC           = 7,
    parameter int EXP                = 8,
    parameter int FRAC               = 7,
    parameter int LINEAR_TO_LOG_BITS = 11
) (
    input logic                        clock,
    input logic                        resetN,
    float_acc_to_log_encoder_if.slave  bus
);

    localparam int ACC_BIAS = exp_bias(ACC_EXP);
    localparam int EXP_BIAS = exp_bias(EXP);
    localparam int K        = min_int(ACC_FRAC, LINEAR_TO_LOG_BITS);
    localparam int OUT_W    = 1 + EXP + FRAC;

    localparam logic signed [DEC_EXP_W-1:0] L_BIAS = DEC_EXP_W'(EXP_BIAS);
    localparam logic signed [DEC_EXP_W-1:0] A_BIAS = DEC_EXP_W'(ACC_BIAS);
    localparam logic signed [DEC_EXP_W-1:0] L_OVF  = DEC_EXP_W'((2**EXP) - 1);
    localparam logic signed [DEC_EXP_W-1:0] L_ZERO = '0;

    // ---------------- input decode ----------------
    logic                        in_sign;
    logic [ACC_EXP-1:0]          in_exp;
    logic [ACC_FRAC-1:0]         in_frac;
    logic [K-1:0]                lut_idx;
    logic [FRAC:0]               lut_entry;
    logic signed [DEC_EXP_W-1:0] exp_unb;
    float_dec_t                  dec;

    assign {in_sign, in_exp, in_frac} = bus.inFloat;
    assign lut_idx = in_frac[ACC_FRAC-1 -: K];

    float_to_log_lut #(.K(K), .FRAC(FRAC)) u_lut (
        .idx   (lut_idx),
        .entry (lut_entry)
    );

    always_comb begin
        exp_unb     = $signed({{(DEC_EXP_W - ACC_EXP){1'b0}}, in_exp}) - A_BIAS;
        dec.sign    = in_sign;
        dec.is_zero = (in_exp == '0);
        dec.is_inf  = &in_exp;         // NaN folds into inf
        dec.exp     = exp_unb;
        dec.frac    = DEC_FRAC_W'(lut_entry);
    end

    // ---------------- pipeline control ----------------
    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic s1_load, s2_load;
    float_dec_t s1_dec_q, s1_dec_d;
    logic [OUT_W-1:0] out_log_q, out_log_d;

    assign s2_load     = !s2_valid_q || bus.outReady;
    assign s1_load     = !s1_valid_q || s2_load;
    assign bus.inReady = s1_load;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_dec_d   = s1_dec_q;
        if (s1_load) begin
            s1_valid_d = bus.inValid;
            if (bus.inValid) s1_dec_d = dec;
        end
    end

    // ---------------- stage 2: rebias, range, pack ----------------
    logic                        carry;
    logic [FRAC-1:0]             log_frac;
    logic signed [DEC_EXP_W-1:0] l_val;
    logic [OUT_W-1:0]            log_c;
    range_t                      range_c;

    always_comb begin
        // A LUT entry of exactly 2^FRAC rolls over into the integer exponent.
        carry    = s1_dec_q.frac[FRAC];
        log_frac = carry ? '0 : s1_dec_q.frac[FRAC-1:0];
        l_val    = $signed(s1_dec_q.exp) + L_BIAS
                   + $signed({{(DEC_EXP_W - 1){1'b0}}, carry});
        range_c  = RANGE_OK;
        log_c    = {s1_dec_q.sign, l_val[EXP-1:0], log_frac};
        if (s1_dec_q.is_zero) begin
            log_c = {s1_dec_q.sign, {EXP{1'b0}}, {FRAC{1'b0}}};
        end else if (s1_dec_q.is_inf) begin
            log_c = {s1_dec_q.sign, {EXP{1'b1}}, {FRAC{1'b0}}};
        end else if (l_val >= L_OVF) begin
            range_c = RANGE_OVF;
            log_c   = {s1_dec_q.sign, {(EXP - 1){1'b1}}, 1'b0, {FRAC{1'b1}}};
        end else if (l_val <= L_ZERO) begin
            range_c = RANGE_UNF;
            log_c   = {s1_dec_q.sign, {EXP{1'b0}}, {FRAC{1'b0}}};
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        out_log_d  = out_log_q;
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) out_log_d = log_c;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_dec_q   <= '0;
            out_log_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_dec_q   <= s1_dec_d;
            out_log_q  <= out_log_d;
        end
    end

    assign bus.outValid = s2_valid_q;
    assign bus.outLog   = out_log_q;

    // Decode-record fraction bits above FRAC are never populated.
    logic unused_bits;
    assign unused_bits = ^s1_dec_q.frac[DEC_FRAC_W-1:FRAC+1];

    // ---------------- optional statistics ----------------
`ifdef FLOAT_TO_LOG_STATS_EN
    range_t      range_q, range_d;
    logic [15:0] ovf_count_q, ovf_count_d;
    logic [15:0] unf_count_q, unf_count_d;
    logic        xfer;

    assign xfer = s2_valid_q && bus.outReady;

    always_comb begin
        range_d     = range_q;
        ovf_count_d = ovf_count_q;
        unf_count_d = unf_count_q;
        if (s2_load && s1_valid_q) range_d = range_c;
        if (xfer && (range_q == RANGE_OVF) && (ovf_count_q != 16'hFFFF))
            ovf_count_d = ovf_count_q + 16'd1;
        if (xfer && (range_q == RANGE_UNF) && (unf_count_q != 16'hFFFF))
            unf_count_d = unf_count_q + 16'd1;
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            range_q     <= RANGE_OK;
            ovf_count_q <= '0;
            unf_count_q <= '0;
        end else begin
            range_q     <= range_d;
            ovf_count_q <= ovf_count_d;
            unf_count_q <= unf_count_d;
        end
    end

    assign bus.ovfCount = ovf_count_q;
    assign bus.unfCount = unf_count_q;
`else
    logic unused_stats;
    assign unused_stats = ^range_c;
    assign bus.ovfCount = '0;
    assign bus.unfCount = '0;
`endif

endmodule

// File: tb/tb_float_acc_to_log_encoder.sv
module tb_float_acc_to_log_encoder;

    logic clock = 1'b0;
    logic resetN;
    always #5 clock = ~clock;

    float_acc_to_log_encoder_if #(.IN_W(16), .OUT_W(16)) bus0 ();
    float_acc_to_log_encoder_if #(.IN_W(18), .OUT_W(16)) bus10 ();

    float_acc_to_log_encoder dut (
        .clock  (clock),
        .resetN (resetN),
        .bus    (bus0)
    );

    float_acc_to_log_encoder #(.ACC_EXP(10)) dut10 (
        .clock  (clock),
        .resetN (resetN),
        .bus    (bus10)
    );

`ifdef FLOAT_TO_LOG_STATS_EN
    localparam logic [15:0] EXP_CNT = 16'd1;
`else
    localparam logic [15:0] EXP_CNT = 16'd0;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_out   = 0;

    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] data;
        int          acc_cyc;
        bit          chk_lat;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic [15:0] in;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Independent reference: real-valued log2 of the mantissa.
    function automatic logic [15:0] model(input logic [15:0] f);
        logic       s;
        int         e, fr, ent, l;
        real        r;
        s  = f[15];
        e  = int'(f[14:7]);
        fr = int'(f[6:0]);
        if (e == 0)   return {s, 15'h0};
        if (e == 255) return {s, 8'hFF, 7'h0};
        r   = $ln(1.0 + real'(fr) / 128.0) / $ln(2.0) * 128.0;
        ent = $rtoi(r + 0.5);
        l   = e - 127 + 127;
        if (ent >= 128) begin
            ent = ent - 128;
            l   = l + 1;
        end
        if (l >= 255) return {s, 8'hFE, 7'h7F};
        if (l <= 0)   return {s, 15'h0};
        return {s, 8'(l), 7'(ent)};
    endfunction

    // Output monitor / scoreboard pop.
    always @(negedge clock) begin
        if (resetN && bus0.outValid && bus0.outReady) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_out: got %h expected no word", bus0.outLog);
            end else begin
                sb_t e;
                e = sb.pop_front();
                check("out_data", 32'(bus0.outLog), 32'(e.data));
                if (e.chk_lat) check("latency", 32'(cyc - e.acc_cyc), 32'd2);
                n_out++;
            end
        end
    end

    task automatic send(input logic [15:0] w, input logic [15:0] expv, input bit lat);
        bit done;
        done = 1'b0;
        bus0.inValid = 1'b1;
        bus0.inFloat = w;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clock);
            if (bus0.inReady) begin
                sb.push_back('{expv, cyc, lat});
                done = 1'b1;
            end
            @(posedge clock);
            #1;
        end
        bus0.inValid = 1'b0;
        if (!done) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(posedge clock);
            t++;
        end
        #1;
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic run10(input logic [17:0] w, input logic [15:0] expv);
        bit got;
        got = 1'b0;
        bus10.inValid = 1'b1;
        bus10.inFloat = w;
        @(negedge clock);
        check("rebias_inready", 32'(bus10.inReady), 32'd1);
        @(posedge clock);
        #1;
        bus10.inValid = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clock);
            if (bus10.outValid) begin
                got = 1'b1;
                check("rebias_out", 32'(bus10.outLog), 32'(expv));
            end
        end
        if (!got) check("rebias_timeout", 32'd0, 32'd1);
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] bp_in  [3];
        logic [15:0] bp_exp [3];
        int          idx;
        int          out_base;

        vecs[0] = '{16'h3F80, 16'h3F80};
        vecs[1] = '{16'h4000, 16'h4000};
        vecs[2] = '{16'h3FC0, 16'h3FCB};
        vecs[3] = '{16'hBFC0, 16'hBFCB};
        vecs[4] = '{16'h0000, 16'h0000};
        vecs[5] = '{16'h8000, 16'h8000};
        vecs[6] = '{16'h7F80, 16'h7F80};
        vecs[7] = '{16'h7FC1, 16'h7F80};
        vecs[8] = '{16'h3FFF, 16'h3FFF};

        resetN = 1'b0;
        bus0.inValid  = 1'b0; bus0.inFloat  = '0; bus0.outReady  = 1'b1;
        bus10.inValid = 1'b0; bus10.inFloat = '0; bus10.outReady = 1'b1;
        repeat (3) @(negedge clock);
        resetN = 1'b1;
        @(negedge clock);
        check("rst_outvalid", 32'(bus0.outValid), 32'd0);
        check("rst_inready",  32'(bus0.inReady),  32'd1);
        check("rst_outlog",   32'(bus0.outLog),   32'd0);
        check("rst_ovf",      32'(bus0.ovfCount), 32'd0);
        check("rst_unf",      32'(bus0.unfCount), 32'd0);
        @(posedge clock);
        #1;

        // Table vectors, back-to-back with outReady high.
        for (int i = 0; i < 9; i++) send(vecs[i].in, vecs[i].exp, 1'b1);
        drain();

        // All 128 fractions at 2^0 and 2^-100, then random words.
        for (int i = 0; i < 128; i++) begin
            send({1'b0, 8'd127, 7'(i)}, model({1'b0, 8'd127, 7'(i)}), 1'b1);
            send({1'b1, 8'd27,  7'(i)}, model({1'b1, 8'd27,  7'(i)}), 1'b1);
        end
        for (int i = 0; i < 40; i++) begin
            logic [15:0] w;
            w = 16'($urandom);
            send(w, model(w), 1'b1);
        end
        drain();

        // Backpressure: 5 cycles of outReady=0 with inValid held.
        bp_in  = '{16'h3F80, 16'h4000, 16'h3FC0};
        bp_exp = '{16'h3F80, 16'h4000, 16'h3FCB};
        out_base = n_out;
        bus0.outReady = 1'b0;
        idx = 0;
        bus0.inValid = 1'b1;
        bus0.inFloat = bp_in[0];
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            if (bus0.inReady && idx < 3) begin
                sb.push_back('{bp_exp[idx], cyc, 1'b0});
                idx++;
            end
            @(posedge clock);
            #1;
            if (idx < 3) bus0.inFloat = bp_in[idx];
        end
        bus0.inValid = 1'b0;
        check("bp_accepted", 32'(idx), 32'd2);
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            check("bp_inready",  32'(bus0.inReady),  32'd0);
            check("bp_outvalid", 32'(bus0.outValid), 32'd1);
            check("bp_stable",   32'(bus0.outLog),   32'h3F80);
        end
        @(posedge clock);
        #1;
        bus0.outReady = 1'b1;
        send(bp_in[2], bp_exp[2], 1'b0);
        drain();
        check("bp_out_count", 32'(n_out - out_base), 32'd3);

        // Rebias limits on the wide-exponent instance.
        run10({1'b0, 10'd639, 7'd0}, 16'h7F7F);
        run10({1'b0, 10'd384, 7'd0}, 16'h0000);
        @(negedge clock);
        check("rebias_ovfcnt", 32'(bus10.ovfCount), 32'(EXP_CNT));
        check("rebias_unfcnt", 32'(bus10.unfCount), 32'(EXP_CNT));
        check("default_ovfcnt", 32'(bus0.ovfCount), 32'd0);
        check("default_unfcnt", 32'(bus0.unfCount), 32'd0);
        @(posedge clock);
        #1;

        // Asynchronous reset with both stages full.
        bus0.outReady = 1'b0;
        send(16'h3F80, 16'h3F80, 1'b0);
        send(16'h4000, 16'h4000, 1'b0);
        @(negedge clock);
        check("prerst_outvalid", 32'(bus0.outValid), 32'd1);
        check("prerst_inready",  32'(bus0.inReady),  32'd0);
        #1;
        resetN = 1'b0;
        #1;
        check("async_outvalid", 32'(bus0.outValid), 32'd0);
        check("async_outlog",   32'(bus0.outLog),   32'd0);
        sb.delete();
        @(negedge clock);
        resetN = 1'b1;
        #1;
        check("post_inready",  32'(bus0.inReady),   32'd1);
        check("post_outvalid", 32'(bus0.outValid),  32'd0);
        check("post_ovf10",    32'(bus10.ovfCount), 32'd0);
        check("post_unf10",    32'(bus10.unfCount), 32'd0);
        @(posedge clock);
        #1;
        bus0.outReady = 1'b1;
        send(16'h3FC0, 16'h3FCB, 1'b1);
        drain();
        repeat (3) @(posedge clock);
        #1;
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
